microwave_panel: RTL and testbench

- Front-panel input conditioner for the microwave controller.
- Takes raw asynchronous switch and button levels, then synchronizes and debounces them.
- Turns button presses into single-cycle start/cancel pulses and accumulates a cooking time from +1 s / +10 s keys.
- Outputs connect directly to the controller's power, timer, door_status, start_button and cancel_button inputs.

---
 rtl/mw_panel_pkg.sv | 35 +++
 rtl/mw_debounce.sv | 60 ++++++
 rtl/microwave_panel.sv | 93 +++++++++
 tb/tb_microwave_panel.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mw_panel_pkg.sv
// rtl/mw_panel_pkg.sv - shared constants, event struct and saturating timer add for the microwave front panel
package mw_panel_pkg;

  localparam int TIMER_W       = 7;
  localparam int DEF_DB_CYCLES = 4;
  localparam int DEF_MAX_TIME  = 120;
  localparam int ADD_SMALL     = 1;
  localparam int ADD_LARGE     = 10;

  // One registered rising-edge event per key
  typedef struct packed {
    logic add1;
    logic add10;
    logic start;
    logic cancel;
  } key_evt_t;

  // Adds the selected increments one bit wider than the timer, then clamps to the ceiling
  function automatic logic [TIMER_W-1:0] sat_add(
    input logic [TIMER_W-1:0] cur,
    input logic               add1,
    input logic               add10,
    input logic [TIMER_W-1:0] ceil_v
  );
    logic [TIMER_W:0] sum;
    sum = {1'b0, cur}
        + (add1  ? (TIMER_W+1)'(ADD_SMALL) : '0)
        + (add10 ? (TIMER_W+1)'(ADD_LARGE) : '0);
    if (sum > {1'b0, ceil_v}) begin
      return ceil_v;
    end
    return sum[TIMER_W-1:0];
  endfunction

endpackage

// File: rtl/mw_debounce.sv
// rtl/mw_debounce.sv - two-flop synchronizer plus stable-count debouncer for one panel input
module mw_debounce
  import mw_panel_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic rise
);

  // The counter only has to count up to DB_CYCLES-1: the flip happens on the edge it would reach DB_CYCLES
  localparam int               CNT_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flip;

  // Next-state: shift the synchronizer, count mismatching cycles, flip the level once the count completes
  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    flip     = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        flip     = 1'b1;
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers; reset drops everything so a half-finished debounce is abandoned
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
  // Combinational: high in the cycle whose closing edge raises the stable level
  assign rise   = flip & sync2_q;

endmodule

// File: rtl/microwave_panel.sv
// rtl/microwave_panel.sv - front-panel conditioner: debounced levels, start/cancel pulses, cooking-time accumulator
module microwave_panel
  import mw_panel_pkg::*;
#(
  parameter int DB_CYCLES  = DEF_DB_CYCLES,
  parameter int MAX_TIME   = DEF_MAX_TIME,
  parameter bit GATE_START = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               raw_door,
  input  logic               raw_power,
  input  logic               raw_start,
  input  logic               raw_cancel,
  input  logic               raw_add1,
  input  logic               raw_add10,
  output logic               door_status,
  output logic               power,
  output logic               start_button,
  output logic               cancel_button,
  output logic [TIMER_W-1:0] timer
);

  localparam logic [TIMER_W-1:0] MAX_T = TIMER_W'(MAX_TIME);

  // Input order: door, power, start, cancel, add1, add10
  logic [5:0] raw_vec;
  logic [5:0] stable_vec;
  logic [5:0] rise_vec;

  assign raw_vec = {raw_add10, raw_add1, raw_cancel, raw_start, raw_power, raw_door};

  for (genvar i = 0; i < 6; i++) begin : g_db
    mw_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (raw_vec[i]),
      .stable(stable_vec[i]),
      .rise  (rise_vec[i])
    );
  end

  // Door/power only need levels; keys only need rising edges
  logic unused_bits;
  assign unused_bits = ^{stable_vec[5:2], rise_vec[1:0]};

  key_evt_t           evt_q, evt_d;
  logic               start_button_q, start_button_d;
  logic               cancel_button_q, cancel_button_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               start_ok;

  // Event capture, start gate (pre-update timer) and timer update with cancel taking priority over adds
  always_comb begin
    evt_d.add1      = rise_vec[4];
    evt_d.add10     = rise_vec[5];
    evt_d.start     = rise_vec[2];
    evt_d.cancel    = rise_vec[3];
    start_ok        = !GATE_START || (stable_vec[0] && (timer_q != '0));
    start_button_d  = evt_q.start && start_ok;
    cancel_button_d = evt_q.cancel;
    timer_d         = timer_q;
    if (evt_q.cancel) begin
      timer_d = '0;
    end else if (evt_q.add1 || evt_q.add10) begin
      timer_d = sat_add(timer_q, evt_q.add1, evt_q.add10, MAX_T);
    end
  end

  // Event, pulse and timer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt_q           <= '0;
      start_button_q  <= 1'b0;
      cancel_button_q <= 1'b0;
      timer_q         <= '0;
    end else begin
      evt_q           <= evt_d;
      start_button_q  <= start_button_d;
      cancel_button_q <= cancel_button_d;
      timer_q         <= timer_d;
    end
  end

  assign door_status   = stable_vec[0];
  assign power         = stable_vec[1];
  assign start_button  = start_button_q;
  assign cancel_button = cancel_button_q;
  assign timer         = timer_q;

endmodule

// File: tb/tb_microwave_panel.sv
// tb/tb_microwave_panel.sv - self-checking bench for microwave_panel with a key-press level reference model
module tb_microwave_panel;

  localparam int MAXT = 120;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       raw_door = 1'b0, raw_power = 1'b0, raw_start = 1'b0;
  logic       raw_cancel = 1'b0, raw_add1 = 1'b0, raw_add10 = 1'b0;
  logic       door_status, power, start_button, cancel_button;
  logic [6:0] timer;

  int checks = 0;
  int errors = 0;

  // Observations from the last press: timer after edges 6 and 7, pulse counts and last pulse edge
  int t6, t7, sc, se, cc, ce;
  int m_timer;
  bit m_door;

  microwave_panel #(
    .DB_CYCLES (4),
    .MAX_TIME  (MAXT),
    .GATE_START(1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .raw_door     (raw_door),
    .raw_power    (raw_power),
    .raw_start    (raw_start),
    .raw_cancel   (raw_cancel),
    .raw_add1     (raw_add1),
    .raw_add10    (raw_add10),
    .door_status  (door_status),
    .power        (power),
    .start_button (start_button),
    .cancel_button(cancel_button),
    .timer        (timer)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_add(input int cur, input bit a1, input bit a10);
    int s;
    s = cur + (a1 ? 1 : 0) + (a10 ? 10 : 0);
    return (s > MAXT) ? MAXT : s;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    raw_door = 0; raw_power = 0; raw_start = 0; raw_cancel = 0; raw_add1 = 0; raw_add10 = 0;
    tick();
    tick();
    reset = 1'b0;
    m_timer = 0;
    m_door = 0;
  endtask

  // Holds the chosen keys for 'hold' edges, then releases for 'gap' edges, recording what the DUT does
  task automatic do_press(input bit a1, input bit a10, input bit st, input bit cn,
                          input int hold, input int gap);
    raw_add1 = a1; raw_add10 = a10; raw_start = st; raw_cancel = cn;
    sc = 0; se = -1; cc = 0; ce = -1; t6 = -1; t7 = -1;
    for (int e = 1; e <= hold + gap; e++) begin
      tick();
      if (e == hold) begin
        raw_add1 = 0; raw_add10 = 0; raw_start = 0; raw_cancel = 0;
      end
      if (e == 6) t6 = int'(timer);
      if (e == 7) t7 = int'(timer);
      if (start_button)  begin sc++; se = e; end
      if (cancel_button) begin cc++; ce = e; end
    end
  endtask

  task automatic set_door(input bit v);
    raw_door = v;
    repeat (10) tick();
    m_door = v;
  endtask

  task automatic test_reset();
    int bad;
    reset = 1'b1;
    tick();
    checks++; if (door_status !== 1'b0)   begin errors++; $display("FAIL rst_door got %0b exp 0", door_status); end
    checks++; if (power !== 1'b0)         begin errors++; $display("FAIL rst_power got %0b exp 0", power); end
    checks++; if (start_button !== 1'b0)  begin errors++; $display("FAIL rst_start got %0b exp 0", start_button); end
    checks++; if (cancel_button !== 1'b0) begin errors++; $display("FAIL rst_cancel got %0b exp 0", cancel_button); end
    checks++; if (timer !== 7'd0)         begin errors++; $display("FAIL rst_timer got %0d exp 0", timer); end
    do_reset();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if ({door_status, power, start_button, cancel_button} !== 4'b0 || timer !== 7'd0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL idle_outputs got %0d nonzero cycles exp 0", bad); end
    // Reset in the middle of a door debounce
    raw_door = 1'b1;
    repeat (4) tick();
    reset = 1'b1;
    #1;
    checks++; if (door_status !== 1'b0) begin errors++; $display("FAIL mid_rst_door got %0b exp 0", door_status); end
    reset = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 5) begin
        checks++; if (door_status !== 1'b0) begin errors++; $display("FAIL mid_rst_e5 got %0b exp 0", door_status); end
      end
      if (e == 6) begin
        checks++; if (door_status !== 1'b1) begin errors++; $display("FAIL mid_rst_e6 got %0b exp 1", door_status); end
      end
    end
  endtask

  task automatic test_door_glitch();
    int hi;
    do_reset();
    raw_door = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 5) begin
        checks++; if (door_status !== 1'b0) begin errors++; $display("FAIL door_e5 got %0b exp 0", door_status); end
      end
      if (e == 6) begin
        checks++; if (door_status !== 1'b1) begin errors++; $display("FAIL door_e6 got %0b exp 1", door_status); end
      end
    end
    raw_power = 1'b1;
    repeat (3) tick();
    raw_power = 1'b0;
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (power !== 1'b0) hi++;
    end
    checks++; if (hi != 0) begin errors++; $display("FAIL power_glitch got %0d high cycles exp 0", hi); end
  endtask

  task automatic test_accumulate();
    do_reset();
    for (int k = 0; k < 11; k++) begin
      bit a1, a10;
      int nxt;
      a1 = (k == 10);
      a10 = (k != 10);
      nxt = model_add(m_timer, a1, a10);
      do_press(a1, a10, 0, 0, 8, 8);
      checks++; if (t6 != m_timer) begin errors++; $display("FAIL acc%0d_e6 got %0d exp %0d", k, t6, m_timer); end
      checks++; if (t7 != nxt)     begin errors++; $display("FAIL acc%0d_e7 got %0d exp %0d", k, t7, nxt); end
      m_timer = nxt;
    end
  endtask

  task automatic test_saturate();
    int exp_v [2];
    exp_v[0] = 111;
    exp_v[1] = 120;
    for (int k = 0; k < 2; k++) begin
      do_press(0, 1, 0, 0, 8, 8);
      checks++; if (t7 != exp_v[k]) begin errors++; $display("FAIL sat%0d got %0d exp %0d", k, t7, exp_v[k]); end
    end
    do_press(0, 0, 0, 1, 8, 8);
    checks++; if (t7 != 0 || cc != 1) begin errors++; $display("FAIL sat_cancel got t=%0d c=%0d exp t=0 c=1", t7, cc); end
    repeat (5) do_press(0, 1, 0, 0, 8, 8);
    checks++; if (int'(timer) != 50) begin errors++; $display("FAIL sat_to50 got %0d exp 50", timer); end
    do_press(1, 1, 0, 0, 8, 8);
    checks++; if (t6 != 50 || t7 != 61) begin errors++; $display("FAIL both_adds got %0d/%0d exp 50/61", t6, t7); end
  endtask

  task automatic test_start_gate();
    do_reset();
    set_door(1);
    repeat (10) do_press(0, 1, 0, 0, 8, 8);
    do_press(0, 0, 1, 0, 20, 8);
    checks++; if (sc != 1 || se != 7) begin errors++; $display("FAIL start_ok got n=%0d e=%0d exp n=1 e=7", sc, se); end
    checks++; if (t7 != 100) begin errors++; $display("FAIL start_timer got %0d exp 100", t7); end
    set_door(0);
    do_press(0, 0, 1, 0, 8, 8);
    checks++; if (sc != 0) begin errors++; $display("FAIL start_door_open got %0d pulses exp 0", sc); end
    set_door(1);
    do_press(0, 0, 0, 1, 8, 8);
    do_press(0, 0, 1, 0, 8, 8);
    checks++; if (sc != 0) begin errors++; $display("FAIL start_timer0 got %0d pulses exp 0", sc); end
  endtask

  task automatic test_cancel_combo();
    do_reset();
    set_door(1);
    repeat (6) do_press(0, 1, 0, 0, 8, 8);
    do_press(0, 1, 1, 1, 8, 8);
    checks++; if (cc != 1 || ce != 7) begin errors++; $display("FAIL combo_cancel got n=%0d e=%0d exp n=1 e=7", cc, ce); end
    checks++; if (sc != 1 || se != 7) begin errors++; $display("FAIL combo_start got n=%0d e=%0d exp n=1 e=7", sc, se); end
    checks++; if (t6 != 60 || t7 != 0) begin errors++; $display("FAIL combo_timer got %0d/%0d exp 60/0", t6, t7); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 30; i++) begin
      bit a1, a10, st, cn, exp_st, pw;
      int hold, gap, nxt, exp_se, exp_ce;
      if ($urandom_range(0, 3) == 0) begin
        pw = 1'($urandom_range(0, 1));
        raw_power = pw;
        set_door(~m_door);
        checks++; if (door_status !== m_door || power !== pw) begin
          errors++; $display("FAIL rnd%0d_levels got %0b%0b exp %0b%0b", i, door_status, power, m_door, pw);
        end
      end
      {a1, a10, st, cn} = 4'($urandom_range(1, 15));
      hold = $urandom_range(6, 12);
      gap = $urandom_range(8, 12);
      exp_st = st && m_door && (m_timer != 0);
      nxt = cn ? 0 : model_add(m_timer, a1, a10);
      exp_se = exp_st ? 7 : -1;
      exp_ce = cn ? 7 : -1;
      do_press(a1, a10, st, cn, hold, gap);
      checks++; if (t7 != nxt) begin errors++; $display("FAIL rnd%0d_timer got %0d exp %0d", i, t7, nxt); end
      checks++; if (sc != int'(exp_st) || se != exp_se) begin
        errors++; $display("FAIL rnd%0d_start got n=%0d e=%0d exp n=%0d e=%0d", i, sc, se, exp_st, exp_se);
      end
      checks++; if (cc != int'(cn) || ce != exp_ce) begin
        errors++; $display("FAIL rnd%0d_cancel got n=%0d e=%0d exp n=%0d e=%0d", i, cc, ce, cn, exp_ce);
      end
      m_timer = nxt;
    end
  endtask

  initial begin
    test_reset();
    test_door_glitch();
    test_accumulate();
    test_saturate();
    test_start_gate();
    test_cancel_combo();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
